sample_fsm: RTL and testbench
=============================

// Module: sample_fsm
// PURPOSE
//  - One-shot pulse stretcher (laser-timer style Moore FSM).
//  - A button input B, sampled high while idle, drives output X high for exactly
//    3 consecutive clock cycles, then X returns low.
//  - Small standalone control block, used as the reference sequential example
//    next to the simple ALU.
// PARAMETERS
//  - none. Pulse length is fixed at 3 cycles by the state set.
// PORTS  (positional order is B, X, Clk, Rst; instances connect by position)
//  - Clk  input   1  Single clock; all state updates occur on the rising edge.
//  - Rst  input   1  Asynchronous, active-high reset. Forces state Off and X=0.
//  - B    input   1  Trigger/button. Sampled on rising Clk edges only.
//  - X    output  1  Stretched pulse. Moore output, decoded from state only.
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//    Rst=1 immediately forces state=Off and X=0, independent of Clk.
//  - X is held at 0 for as long as Rst stays high.
//  - States (2-bit register):
//      Off=2'b00 (X=0)
//      On1=2'b01 (X=1)
//      On2=2'b10 (X=1)
//      On3=2'b11 (X=1)
//  - Transitions on the rising edge of Clk, when Rst=0:
//      Off: B=1 -> On1; B=0 -> Off
//      On1 -> On2 (unconditional)
//      On2 -> On3 (unconditional)
//      On3 -> Off (unconditional)
//  - B is ignored in On1, On2 and On3. A retrigger during a pulse neither extends
//    nor restarts it.
//  - If B is still 1 when the FSM returns to Off, the next edge re-enters On1.
//    So B held high continuously gives X = 1,1,1,0 repeating (period 4 cycles).
//  - Latency: B=1 sampled at edge k gives X=1 after edge k, through edge k+3.
//    X falls after edge k+3.
//  - X must be glitch-free. Decode it combinationally from the state register only,
//    never from B. Equivalent: X = (state != Off).
//  - Reset asserted mid-pulse aborts the pulse: X=0 at once. After Rst is released
//    the FSM waits in Off for a new B.
//  - No unreachable states exist: all 4 encodings are used. A default branch
//    must still go to Off.
//  - Release of Rst is expected away from the Clk rising edge (the bench releases
//    it 5 ns after an edge).
// STRUCTURE
//  - State encoding localparams (S_OFF, S_ON1, S_ON2, S_ON3) go in a shared package
//    or include. The wider design reuses them.
//  - Implement in three parts:
//      one sequential always block (async reset, state register)
//      one combinational next-state block
//      one combinational output decode
//  - No sub-module; the block is too small to split.
// TESTING  (20 ns clock period; stimulus changes 5 ns after a rising edge)
//  1. Rst=1, B=0 for one edge -> X=0 throughout, state=Off.
//  2. Release Rst, B=1 for exactly one edge, then B=0.
//     -> X=1 for the next 3 cycles (60 ns), then X=0 and stays 0.
//  3. B held 1 continuously from Off -> X pattern 1,1,1,0,1,1,1,0 on successive edges.
//  4. B pulses 1 again while in On2 -> pulse not extended. X falls 3 cycles after
//     the original trigger.
//  5. Assert Rst for 3 ns mid-cycle while in On1
//     -> X drops to 0 immediately, before the next edge. After release X stays 0
//     until B=1 is sampled.
//  6. B=0 for 10 cycles after reset -> X stays 0; state never leaves Off.

Source files
------------

// File: rtl/sample_fsm_pkg.sv
// Shared state encodings for the one-shot pulse stretcher.
// The raw localparams are reused elsewhere; the enum gives the FSM a typed view of them.
package sample_fsm_pkg;

    localparam logic [1:0] S_OFF = 2'b00;
    localparam logic [1:0] S_ON1 = 2'b01;
    localparam logic [1:0] S_ON2 = 2'b10;
    localparam logic [1:0] S_ON3 = 2'b11;

    typedef enum logic [1:0] {
        OFF = S_OFF,
        ON1 = S_ON1,
        ON2 = S_ON2,
        ON3 = S_ON3
    } state_e;

endpackage

// File: rtl/sample_fsm.sv
// One-shot pulse stretcher: B sampled high while idle drives X high for exactly
// three clock cycles; retriggers during the pulse are ignored.
module sample_fsm
    import sample_fsm_pkg::*;
(
    input  logic B,
    output logic X,
    input  logic Clk,
    input  logic Rst
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= OFF;
        end else begin
            state_q <= state_d;
        end
    end

    // B only matters in OFF; the pulse states advance unconditionally.
    always_comb begin
        state_d = OFF;
        case (state_q)
            OFF:     state_d = B ? ON1 : OFF;
            ON1:     state_d = ON2;
            ON2:     state_d = ON3;
            ON3:     state_d = OFF;
            default: state_d = OFF;
        endcase
    end

    // Moore decode from the register alone keeps X glitch-free with respect to B.
    always_comb begin
        X = 1'b0;
        if (state_q != OFF) begin
            X = 1'b1;
        end
    end

endmodule

// File: tb/tb_sample_fsm.sv
// Testbench for sample_fsm: directed steps followed by random B traffic with
// occasional mid-cycle resets, checked against a pulse-remaining counter model.
module tb_sample_fsm;

    logic B;
    logic X;
    logic Clk;
    logic Rst;

    int compared = 0;
    int mismatched = 0;
    int remaining = 0;
    logic [3:0] heldPattern = 4'b1110;

    sample_fsm dut (
        .B   (B),
        .X   (X),
        .Clk (Clk),
        .Rst (Rst)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkState(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: state=%b expected=%b at %0t", tag, observed, expected, $time);
        end
    endtask

    // Called 5 ns after an edge (or later): drive B, cross one rising edge,
    // advance the model, then check X 5 ns after that edge.
    task automatic applyStimulus(input logic bNext, input string tag);
        B = bNext;
        @(posedge Clk);
        if (remaining > 0) remaining--;
        else if (bNext) remaining = 3;
        #5;
        checkOutput(tag, X, remaining > 0);
    endtask

    // 3 ns reset pulse that starts at the current (mid-cycle) time.
    task automatic pulseReset(input string tag);
        Rst = 1'b1;
        #1;
        remaining = 0;
        checkOutput(tag, X, 1'b0);
        #2;
        Rst = 1'b0;
    endtask

    initial begin
        B = 1'b0;
        Rst = 1'b1;

        // Step 1: reset held across an edge.
        #1;
        checkOutput("reset_async", X, 1'b0);
        @(posedge Clk);
        #5;
        checkOutput("reset_edge", X, 1'b0);
        checkState("reset_state", dut.state_q, 2'b00);
        Rst = 1'b0;

        // Step 2: single-cycle trigger yields exactly three high cycles.
        applyStimulus(1'b1, "oneshot");
        checkOutput("oneshot_c1", X, 1'b1);
        applyStimulus(1'b0, "oneshot");
        checkOutput("oneshot_c2", X, 1'b1);
        applyStimulus(1'b0, "oneshot");
        checkOutput("oneshot_c3", X, 1'b1);
        applyStimulus(1'b0, "oneshot");
        checkOutput("oneshot_fall", X, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, "oneshot_idle");

        // Step 3: B held high gives 1,1,1,0 repeating.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, "held");
            checkOutput("held_pattern", X, heldPattern[3 - (i % 4)]);
        end
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, "drain");

        // Step 4: retrigger while in On2 must not extend the pulse.
        applyStimulus(1'b1, "retrig");
        applyStimulus(1'b0, "retrig");
        applyStimulus(1'b1, "retrig");
        applyStimulus(1'b0, "retrig");
        checkOutput("retrig_fall", X, 1'b0);
        applyStimulus(1'b0, "retrig_idle");

        // Step 5: mid-cycle reset while in On1 aborts the pulse at once.
        applyStimulus(1'b1, "abort_arm");
        checkOutput("abort_on1", X, 1'b1);
        B = 1'b0;
        pulseReset("abort_async");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, "abort_idle");
        applyStimulus(1'b1, "abort_retrigger");
        checkOutput("abort_retrigger_high", X, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, "abort_drain");

        // Step 6: ten idle cycles after reset never leave Off.
        pulseReset("idle_reset");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, "idle");
            checkState("idle_state", dut.state_q, 2'b00);
        end

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), "random");
            if ($urandom_range(0, 19) == 0) pulseReset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
